// File: rtl/seq_combo_lock.sv
// Multi-digit sequential combination lock with attempt counting, timed lockout
// and in-place reprogramming. Define COMBO_AUTORELOCK_EN for the open timeout.
module seq_combo_lock #(
   parameter int DIGIT_W        = 4,
   parameter int SEQ_LEN        = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 50_000_000,
   parameter int OPEN_CYCLES    = 500_000_000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DIGIT_W-1:0]             digit_in,
   input  logic                           enter,
   input  logic                           clear,
   input  logic                           prog,
   output logic                           unlocked,
   output logic                           lockout,
   output logic [$clog2(SEQ_LEN+1)-1:0]   progress,
   output logic [$clog2(MAX_TRIES+1)-1:0] fail_count,
   output logic [DIGIT_W*SEQ_LEN-1:0]     code_out
);

   localparam int IW = $clog2(SEQ_LEN+1);
   localparam int FW = $clog2(MAX_TRIES+1);
   localparam int TW = $clog2(LOCKOUT_CYCLES+1);
   localparam int CW = DIGIT_W*SEQ_LEN;

   typedef enum logic [1:0] {
      S_LOCKED,
      S_OPEN,
      S_PROGRAM,
      S_LOCKOUT
   } state_t;

   state_t          state;
   logic [CW-1:0]   code;
   logic [CW-1:0]   shadow;
   logic [IW-1:0]   idx;
   logic            mismatch;
   logic [FW-1:0]   fails;
   logic [TW-1:0]   timer;
   logic            enter_q;

   logic            er;
   logic            last;
   logic            miss;
   logic [CW-1:0]   merged;
   logic [FW-1:0]   fail_inc;

`ifdef COMBO_AUTORELOCK_EN
   localparam int OW = $clog2(OPEN_CYCLES+1);
   logic [OW-1:0]   open_timer;
`else
   logic [31:0]     unused_open;
   assign unused_open = 32'(OPEN_CYCLES);
`endif

   always_comb begin
      er       = enter & ~enter_q;
      last     = (idx == IW'(SEQ_LEN-1));
      miss     = mismatch | (digit_in != code[idx*DIGIT_W +: DIGIT_W]);
      merged   = shadow;
      merged[idx*DIGIT_W +: DIGIT_W] = digit_in;
      fail_inc = fails + FW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_LOCKED;
         code     <= '0;
         shadow   <= '0;
         idx      <= '0;
         mismatch <= 1'b0;
         fails    <= '0;
         timer    <= '0;
         enter_q  <= 1'b0;
`ifdef COMBO_AUTORELOCK_EN
         open_timer <= '0;
`endif
      end else begin
         enter_q <= enter;
         unique case (state)
            S_LOCKED: begin
               if (clear) begin
                  idx      <= '0;
                  mismatch <= 1'b0;
               end else if (er) begin
                  if (last) begin
                     idx      <= '0;
                     mismatch <= 1'b0;
                     if (!miss) begin
                        state <= S_OPEN;
                        fails <= '0;
`ifdef COMBO_AUTORELOCK_EN
                        open_timer <= OW'(OPEN_CYCLES-1);
`endif
                     end else if (fails < FW'(MAX_TRIES)) begin
                        fails <= fail_inc;
                        if (fail_inc == FW'(MAX_TRIES)) begin
                           state <= S_LOCKOUT;
                           timer <= TW'(LOCKOUT_CYCLES-1);
                        end
                     end
                  end else begin
                     idx      <= idx + IW'(1);
                     mismatch <= miss;
                  end
               end
            end
            S_OPEN: begin
               // a keypress always beats the relock timeout
               if (er) begin
                  state <= prog ? S_PROGRAM : S_LOCKED;
                  idx   <= '0;
               end
`ifdef COMBO_AUTORELOCK_EN
               else if (open_timer == '0) begin
                  state <= S_LOCKED;
               end else begin
                  open_timer <= open_timer - OW'(1);
               end
`endif
            end
            S_PROGRAM: begin
               if (clear) begin
                  state <= S_OPEN;
                  idx   <= '0;
`ifdef COMBO_AUTORELOCK_EN
                  open_timer <= OW'(OPEN_CYCLES-1);
`endif
               end else if (er) begin
                  shadow <= merged;
                  if (last) begin
                     code  <= merged;
                     state <= S_OPEN;
                     idx   <= '0;
`ifdef COMBO_AUTORELOCK_EN
                     open_timer <= OW'(OPEN_CYCLES-1);
`endif
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            S_LOCKOUT: begin
               if (timer == '0) begin
                  state <= S_LOCKED;
                  fails <= '0;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= S_LOCKED;
         endcase
      end
   end

   assign unlocked   = (state == S_OPEN) || (state == S_PROGRAM);
   assign lockout    = (state == S_LOCKOUT);
   assign progress   = idx;
   assign fail_count = fails;
   assign code_out   = code;

endmodule

// File: tb/tb_seq_combo_lock.sv
// Directed bench for seq_combo_lock: entry, reprogram, failures, lockout,
// held key, clear and mid-sequence reset.
module tb_seq_combo_lock;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  digit_in;
   logic        enter;
   logic        clear;
   logic        prog;
   logic        unlocked;
   logic        lockout;
   logic [2:0]  progress;
   logic [1:0]  fail_count;
   logic [15:0] code_out;

   int total = 0;
   int bad   = 0;
   int cnt;

   seq_combo_lock #(
      .DIGIT_W(4),
      .SEQ_LEN(4),
      .MAX_TRIES(3),
      .LOCKOUT_CYCLES(20),
      .OPEN_CYCLES(100)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .digit_in(digit_in),
      .enter(enter),
      .clear(clear),
      .prog(prog),
      .unlocked(unlocked),
      .lockout(lockout),
      .progress(progress),
      .fail_count(fail_count),
      .code_out(code_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] d);
      @(negedge clk);
      digit_in = d;
      enter    = 1'b1;
      @(negedge clk);
      enter    = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; digit_in = '0; enter = 1'b0; clear = 1'b0; prog = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_unlocked", 32'(unlocked), 0);
      check("rst_lockout", 32'(lockout), 0);
      check("rst_progress", 32'(progress), 0);
      check("rst_fail", 32'(fail_count), 0);
      check("rst_code", 32'(code_out), 0);
      rst_n = 1'b1;

      press(0); check("p1", 32'(progress), 1);
      press(0); check("p2", 32'(progress), 2);
      press(0); check("p3", 32'(progress), 3);
      press(0);
      check("open0_progress", 32'(progress), 0);
      check("open0_unlocked", 32'(unlocked), 1);
      check("open0_fail", 32'(fail_count), 0);

      prog = 1'b1; press(9); prog = 1'b0;
      check("prog_enter_unl", 32'(unlocked), 1);
      press(1); press(2);
      check("prog_progress", 32'(progress), 2);
      press(3); press(4);
      check("prog_code", 32'(code_out), 32'h4321);
      check("prog_unl", 32'(unlocked), 1);
      check("prog_done_prog", 32'(progress), 0);

      press(0); check("relock", 32'(unlocked), 0);
      press(1); press(2); press(3); press(4);
      check("open_new", 32'(unlocked), 1);
      press(0); check("relock2", 32'(unlocked), 0);

      press(5);
      check("wrong_p1", 32'(progress), 1);
      check("wrong_unl1", 32'(unlocked), 0);
      press(2); press(3); press(4);
      check("wrong_unl", 32'(unlocked), 0);
      check("wrong_fail", 32'(fail_count), 1);
      check("wrong_prog", 32'(progress), 0);

      @(negedge clk);
      digit_in = 4'd0; enter = 1'b1;
      repeat (10) @(negedge clk);
      enter = 1'b0;
      @(negedge clk);
      check("hold_progress", 32'(progress), 1);
      press(2); check("pre_clear", 32'(progress), 2);
      do_clear();
      check("clear_progress", 32'(progress), 0);
      check("clear_fail", 32'(fail_count), 1);

      @(negedge clk);
      clear = 1'b1; enter = 1'b1; digit_in = 4'd1;
      @(negedge clk);
      clear = 1'b0; enter = 1'b0;
      check("clear_wins", 32'(progress), 0);

      press(5); press(5); press(5); press(5);
      check("fail2", 32'(fail_count), 2);
      press(1); press(2); press(3); press(5);
      check("fail3", 32'(fail_count), 3);
      check("lockout_on", 32'(lockout), 1);

      // correct code typed while locked out must be ignored
      cnt = 0;
      while (lockout === 1'b1 && cnt < 100) begin
         if (cnt < 8) begin
            enter    = ~cnt[0];
            digit_in = 4'(cnt/2 + 1);
         end else begin
            enter = 1'b0;
         end
         if (cnt == 9) check("lockout_prog", 32'(progress), 0);
         @(negedge clk);
         cnt++;
      end
      enter = 1'b0;
      check("lockout_len", 32'(cnt), 20);
      check("post_lo_fail", 32'(fail_count), 0);
      check("post_lo_unl", 32'(unlocked), 0);
      check("post_lo_prog", 32'(progress), 0);
      press(1); press(2); press(3); press(4);
      check("post_lo_open", 32'(unlocked), 1);

      prog = 1'b1; press(0); prog = 1'b0;
      press(9); press(8);
      check("mid_prog_p", 32'(progress), 2);
      do_clear();
      check("abort_code", 32'(code_out), 32'h4321);
      check("abort_unl", 32'(unlocked), 1);
      check("abort_prog", 32'(progress), 0);
      press(0); check("abort_relock", 32'(unlocked), 0);

      press(1); press(2);
      check("mid_rst_pre", 32'(progress), 2);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_prog", 32'(progress), 0);
      check("mid_rst_code", 32'(code_out), 0);
      check("mid_rst_unl", 32'(unlocked), 0);
      check("mid_rst_lo", 32'(lockout), 0);
      check("mid_rst_fail", 32'(fail_count), 0);
      rst_n = 1'b1;
      press(0); press(0); press(0); press(0);
      check("rst_code_opens", 32'(unlocked), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
